// File: rtl/numread.sv
// numread: recovers the 13-bit segment code of a rendered digit by majority vote of dark pixels
// inside each segment region, evaluated once per frame at the latch pixel (100,1).
module numread #(
   parameter logic [10:0] width    = 11'd70,
   parameter logic [9:0]  high     = 10'd140,
   parameter logic [9:0]  m_t      = 10'd66,
   parameter logic [3:0]  d        = 4'd8,
   parameter logic [10:0] L1       = 11'd150,
   parameter logic [9:0]  L2       = 10'd150,
   parameter logic [7:0]  DARK_TH  = 8'd64,
   parameter logic [2:0]  STABLE_N = 3'd3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] l,
   input  logic [9:0]  t,
   input  logic [10:0] RGB_x_Src,
   input  logic [9:0]  RGB_y_Src,
   input  logic [23:0] RGB_Data_In,
   input  logic        pix_valid,
   output logic [12:0] seg_code,
   output logic        code_valid,
   output logic        code_stable
);
   // one extra bit of coordinate headroom so l+width+40 and t+high+5 never wrap
   localparam int W = 12;
   localparam logic [W-1:0] DW = {8'd0, d};

   typedef enum logic [1:0] {S_WAIT = 2'd0, S_ACC = 2'd1, S_EVAL = 2'd2} state_t;

   state_t         r_state, w_state_next;
   logic [W-1:0]   r_l, r_r, r_t, r_b, r_x1, r_x2, r_y1, r_y2, r_y3;
   logic [W-1:0]   w_x, w_y, w_x1d, w_x2d, w_y1d, w_y2d, w_y3d;
   logic           w_latch, w_dark, w_in_box;
   logic [12:0]    w_hit, w_sel, w_bit;
   logic [13:1]    w_taken;
   logic           w_geo_load, w_count, w_eval_load, w_clear;
   logic [12:0]    r_seg_code;
   logic           r_code_valid, r_code_stable;
   logic [2:0]     r_run, w_run_next;

   function automatic logic incl(input logic [W-1:0] v, input logic [W-1:0] lo, input logic [W-1:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

   function automatic logic excl(input logic [W-1:0] v, input logic [W-1:0] lo, input logic [W-1:0] hi);
      return (v > lo) && (v < hi);
   endfunction

   assign w_x      = {1'b0, RGB_x_Src};
   assign w_y      = {2'b0, RGB_y_Src};
   assign w_latch  = (RGB_x_Src == 11'd100) && (RGB_y_Src == 10'd1);
   assign w_dark   = (RGB_Data_In[23:16] < DARK_TH) && (RGB_Data_In[15:8] < DARK_TH) &&
                     (RGB_Data_In[7:0] < DARK_TH);
   assign w_in_box = pix_valid && (w_x >= r_l) && (w_x <= r_r) && (w_y >= r_t) && (w_y <= r_b);

   assign w_x1d = r_x1 + DW;
   assign w_x2d = r_x2 - DW;
   assign w_y1d = r_y1 + DW;
   assign w_y2d = r_y2 + DW;
   assign w_y3d = r_y3 - DW;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_l  <= '0; r_r  <= '0; r_t  <= '0; r_b  <= '0;
         r_x1 <= '0; r_x2 <= '0; r_y1 <= '0; r_y2 <= '0; r_y3 <= '0;
      end else if (w_geo_load) begin
         r_l  <= {1'b0, l};
         r_r  <= {1'b0, l} + {1'b0, L1};
         r_x1 <= {1'b0, l} + 12'd40;
         r_x2 <= {1'b0, l} + {1'b0, width} + 12'd40;
         r_t  <= {2'b0, t};
         r_b  <= {2'b0, t} + {2'b0, L2};
         r_y1 <= {2'b0, t} + 12'd5;
         r_y2 <= {2'b0, t} + {2'b0, m_t} + 12'd5;
         r_y3 <= {2'b0, t} + {2'b0, high} + 12'd5;
      end
   end

   // bars use inclusive bounds, corners strict bounds
   always_comb begin
      w_hit     = '0;
      w_hit[12] = incl(w_x, w_x1d, w_x2d) && incl(w_y, r_y1,  w_y1d);
      w_hit[11] = incl(w_x, w_x2d, r_x2)  && incl(w_y, w_y1d, r_y2);
      w_hit[10] = incl(w_x, w_x2d, r_x2)  && incl(w_y, w_y2d, w_y3d);
      w_hit[9]  = incl(w_x, w_x1d, w_x2d) && incl(w_y, w_y3d, r_y3);
      w_hit[8]  = incl(w_x, r_x1,  w_x1d) && incl(w_y, w_y2d, w_y3d);
      w_hit[7]  = incl(w_x, r_x1,  w_x1d) && incl(w_y, w_y1d, r_y2);
      w_hit[6]  = incl(w_x, w_x1d, w_x2d) && incl(w_y, r_y2,  w_y2d);
      w_hit[5]  = excl(w_x, r_x1,  w_x1d) && excl(w_y, r_y1,  w_y1d);
      w_hit[4]  = excl(w_x, w_x2d, r_x2)  && excl(w_y, r_y1,  w_y1d);
      w_hit[3]  = excl(w_x, w_x2d, r_x2)  && excl(w_y, r_y2,  w_y2d);
      w_hit[2]  = excl(w_x, w_x2d, r_x2)  && excl(w_y, w_y3d, r_y3);
      w_hit[1]  = excl(w_x, r_x1,  w_x1d) && excl(w_y, w_y3d, r_y3);
      w_hit[0]  = excl(w_x, r_x1,  w_x1d) && excl(w_y, r_y2,  w_y2d);
   end

   assign w_taken[13] = 1'b0;

   genvar gi;
   generate
      for (gi = 0; gi < 13; gi++) begin : g_region
         logic [9:0] r_tot, r_dk;

         assign w_sel[gi] = w_hit[gi] & ~w_taken[gi+1];
         if (gi > 0) begin : g_chain
            assign w_taken[gi] = w_taken[gi+1] | w_hit[gi];
         end

         always_ff @(posedge clk) begin
            if (rst || w_clear) begin
               r_tot <= '0;
               r_dk  <= '0;
            end else if (w_count && w_in_box && w_sel[gi]) begin
               if (r_tot != 10'h3FF) r_tot <= r_tot + 10'd1;
               if (w_dark && (r_dk != 10'h3FF)) r_dk <= r_dk + 10'd1;
            end
         end

         assign w_bit[gi] = {r_dk, 1'b0} > {1'b0, r_tot};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_WAIT;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_WAIT:  if (w_latch) w_state_next = S_ACC;
         S_ACC:   if (w_latch) w_state_next = S_EVAL;
         S_EVAL:  w_state_next = S_ACC;
         default: w_state_next = S_WAIT;
      endcase
   end

   // the code is registered on the latch edge so it appears together with code_valid in EVAL
   always_comb begin
      w_geo_load  = 1'b0;
      w_count     = 1'b0;
      w_eval_load = 1'b0;
      w_clear     = 1'b0;
      case (r_state)
         S_WAIT: begin
            w_geo_load = w_latch;
            w_clear    = w_latch;
         end
         S_ACC: begin
            w_geo_load  = w_latch;
            w_eval_load = w_latch;
            w_count     = ~w_latch;
         end
         S_EVAL:  w_clear = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      if (w_bit == r_seg_code) w_run_next = (r_run >= STABLE_N) ? STABLE_N : r_run + 3'd1;
      else                     w_run_next = 3'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_seg_code    <= '0;
         r_code_valid  <= 1'b0;
         r_code_stable <= 1'b0;
         r_run         <= '0;
      end else begin
         r_code_valid <= w_eval_load;
         if (w_eval_load) begin
            r_seg_code    <= w_bit;
            r_run         <= w_run_next;
            r_code_stable <= (w_run_next == STABLE_N);
         end
      end
   end

   assign seg_code    = r_seg_code;
   assign code_valid  = r_code_valid;
   assign code_stable = r_code_stable;
endmodule

// File: tb/tb_numread.sv
// Bench for numread: directed frame table, region-12 threshold/saturation sequences, reset and
// randomized frames checked against a region/majority model built from the geometry rules.
module tb_numread;
   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] l;
   logic [9:0]  t;
   logic [10:0] RGB_x_Src;
   logic [9:0]  RGB_y_Src;
   logic [23:0] RGB_Data_In;
   logic        pix_valid;
   logic [12:0] seg_code;
   logic        code_valid;
   logic        code_stable;

   numread dut (
      .clk(clk), .rst(rst), .l(l), .t(t),
      .RGB_x_Src(RGB_x_Src), .RGB_y_Src(RGB_y_Src), .RGB_Data_In(RGB_Data_In),
      .pix_valid(pix_valid), .seg_code(seg_code), .code_valid(code_valid),
      .code_stable(code_stable)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int n_spur = 0;

   // model state
   int          m_tot[13];
   int          m_dark[13];
   bit          m_active;
   logic [12:0] hist[$];
   int          g_l, g_t, g_x1, g_x2, g_y1, g_y2, g_y3;

   typedef struct {
      logic [12:0] mask;
      logic [12:0] exp_code;
      bit          exp_st;
   } vec_t;
   vec_t tbl[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bit is_dark(input logic [23:0] c);
      return (c[23:16] < 8'd64) && (c[15:8] < 8'd64) && (c[7:0] < 8'd64);
   endfunction

   function automatic logic [23:0] mk_color(input bit dk);
      logic [7:0] ch[3];
      int k;
      for (int i = 0; i < 3; i++)
         ch[i] = dk ? 8'($urandom_range(0, 63)) : 8'($urandom_range(0, 255));
      k = $urandom_range(0, 2);
      if (dk) begin
         if ($urandom_range(0, 7) == 0) ch[k] = 8'd63;
      end else begin
         ch[k] = ($urandom_range(0, 3) == 0) ? 8'd64 : 8'($urandom_range(64, 255));
      end
      return {ch[0], ch[1], ch[2]};
   endfunction

   // rectangle table of every region; corners converted from strict to inclusive bounds
   function automatic int region_of(input int x, input int y);
      int xl[13], xh[13], yl[13], yh[13];
      int a, b, c, e, f;
      a = g_x1; b = g_x2; c = g_y1; e = g_y2; f = g_y3;
      xl[12] = a + 8; xh[12] = b - 8; yl[12] = c;     yh[12] = c + 8;
      xl[11] = b - 8; xh[11] = b;     yl[11] = c + 8; yh[11] = e;
      xl[10] = b - 8; xh[10] = b;     yl[10] = e + 8; yh[10] = f - 8;
      xl[9]  = a + 8; xh[9]  = b - 8; yl[9]  = f - 8; yh[9]  = f;
      xl[8]  = a;     xh[8]  = a + 8; yl[8]  = e + 8; yh[8]  = f - 8;
      xl[7]  = a;     xh[7]  = a + 8; yl[7]  = c + 8; yh[7]  = e;
      xl[6]  = a + 8; xh[6]  = b - 8; yl[6]  = e;     yh[6]  = e + 8;
      xl[5]  = a + 1; xh[5]  = a + 7; yl[5]  = c + 1; yh[5]  = c + 7;
      xl[4]  = b - 7; xh[4]  = b - 1; yl[4]  = c + 1; yh[4]  = c + 7;
      xl[3]  = b - 7; xh[3]  = b - 1; yl[3]  = e + 1; yh[3]  = e + 7;
      xl[2]  = b - 7; xh[2]  = b - 1; yl[2]  = f - 7; yh[2]  = f - 1;
      xl[1]  = a + 1; xh[1]  = a + 7; yl[1]  = f - 7; yh[1]  = f - 1;
      xl[0]  = a + 1; xh[0]  = a + 7; yl[0]  = e + 1; yh[0]  = e + 7;
      for (int n = 12; n >= 0; n--)
         if (x >= xl[n] && x <= xh[n] && y >= yl[n] && y <= yh[n]) return n;
      return -1;
   endfunction

   function automatic logic [12:0] model_code();
      logic [12:0] c;
      for (int n = 0; n < 13; n++) c[n] = (2 * m_dark[n]) > m_tot[n];
      return c;
   endfunction

   function automatic bit model_stable(input logic [12:0] c);
      int run;
      run = 1;
      for (int i = hist.size() - 1; i >= 0; i--) begin
         if (hist[i] != c) break;
         run++;
      end
      return run >= 3;
   endfunction

   task automatic model_clear();
      for (int n = 0; n < 13; n++) begin
         m_tot[n]  = 0;
         m_dark[n] = 0;
      end
   endtask

   task automatic drive(input int x, input int y, input logic [23:0] c, input bit v);
      int r;
      RGB_x_Src   = x[10:0];
      RGB_y_Src   = y[9:0];
      RGB_Data_In = c;
      pix_valid   = v;
      if (m_active && v && x >= g_l && x <= g_l + 150 && y >= g_t && y <= g_t + 150) begin
         r = region_of(x, y);
         if (r >= 0) begin
            if (m_tot[r] < 1023) m_tot[r]++;
            if (is_dark(c) && m_dark[r] < 1023) m_dark[r]++;
         end
      end
      step();
      if (code_valid) n_spur++;
   endtask

   task automatic latch_check(input bit ev, input logic [12:0] ec, input bit es, input string tag);
      logic [12:0] c;
      RGB_x_Src   = 11'd100;
      RGB_y_Src   = 10'd1;
      RGB_Data_In = mk_color(1);
      pix_valid   = 1'b1;
      step();
      check({tag, "_valid"}, 32'(code_valid), 32'(ev));
      check({tag, "_code"}, 32'(seg_code), 32'(ec));
      check({tag, "_stable"}, 32'(code_stable), 32'(es));
      $display("latch %s: valid=%0d code=%h stable=%0d (want %0d %h %0d)",
               tag, code_valid, seg_code, code_stable, ev, ec, es);
      if (m_active) begin
         c = model_code();
         hist.push_back(c);
         model_clear();
      end
      m_active = 1'b1;
      g_l = int'(l); g_t = int'(t);
      g_x1 = g_l + 40; g_x2 = g_l + 110;
      g_y1 = g_t + 5;  g_y2 = g_t + 71; g_y3 = g_t + 145;
      RGB_x_Src = '0;
      RGB_y_Src = '0;
      pix_valid = 1'b0;
      step();
      check({tag, "_pulse_end"}, 32'(code_valid), 32'd0);
   endtask

   task automatic render(input logic [12:0] mask, input bit rnd, input bit vld);
      int prob[13];
      int r;
      bit dk;
      for (int n = 0; n < 13; n++) prob[n] = $urandom_range(0, 100);
      for (int y = g_y1; y <= g_y3; y++) begin
         if (rnd && y == g_y2) begin
            l = 11'($urandom);
            t = 10'($urandom);
         end
         for (int x = g_x1; x <= g_x2; x++) begin
            r = region_of(x, y);
            if (r < 0) begin
               if (rnd && $urandom_range(0, 63) == 0) drive(x, y, mk_color(1), 1'b1);
            end else begin
               dk = rnd ? ($urandom_range(0, 99) < prob[r]) : mask[r];
               if (rnd && $urandom_range(0, 15) == 0) drive(x, y, mk_color(1), 1'b0);
               drive(x, y, mk_color(dk), vld);
            end
         end
      end
   endtask

   task automatic render12(input int ndark, input int npix);
      int cnt;
      cnt = 0;
      while (cnt < npix) begin
         for (int y = g_y1; y <= g_y1 + 8; y++)
            for (int x = g_x1; x <= g_x2; x++)
               if (cnt < npix && region_of(x, y) == 12) begin
                  drive(x, y, mk_color(cnt < ndark), 1'b1);
                  cnt++;
               end
      end
   endtask

   initial begin
      logic [12:0] pc;
      tbl[0] = '{13'h1FFF, 13'h1FFF, 1'b0};
      tbl[1] = '{13'h0000, 13'h0000, 1'b0};
      tbl[2] = '{13'h0C18, 13'h0C18, 1'b0};
      tbl[3] = '{13'h0C18, 13'h0C18, 1'b0};
      tbl[4] = '{13'h0C18, 13'h0C18, 1'b1};
      tbl[5] = '{13'h1FFF, 13'h1FFF, 1'b0};

      m_active = 1'b0;
      model_clear();
      g_l = 200; g_t = 100; g_x1 = 240; g_x2 = 310; g_y1 = 105; g_y2 = 171; g_y3 = 245;
      rst = 1'b1; l = 11'd200; t = 10'd100;
      RGB_x_Src = '0; RGB_y_Src = '0; RGB_Data_In = '0; pix_valid = 1'b0;
      repeat (3) step();
      check("reset_code", 32'(seg_code), 32'd0);
      check("reset_valid", 32'(code_valid), 32'd0);
      check("reset_stable", 32'(code_stable), 32'd0);
      rst = 1'b0;

      latch_check(1'b0, 13'h0000, 1'b0, "first_latch");
      for (int i = 0; i < 6; i++) begin
         render(tbl[i].mask, 1'b0, 1'b1);
         latch_check(1'b1, tbl[i].exp_code, tbl[i].exp_st, $sformatf("table%0d", i));
      end

      render12(247, 495);
      latch_check(1'b1, 13'h0000, 1'b0, "half_247");
      render12(248, 495);
      latch_check(1'b1, 13'h1000, 1'b0, "half_248");
      render12(100, 1100);
      latch_check(1'b1, 13'h0000, 1'b0, "saturate");
      render(13'h1FFF, 1'b0, 1'b0);
      latch_check(1'b1, 13'h0000, 1'b0, "no_valid");

      for (int i = 0; i < 4; i++) begin
         render(13'h0000, 1'b1, 1'b1);
         l = 11'($urandom_range(0, 1700));
         t = 10'($urandom_range(0, 700));
         pc = model_code();
         latch_check(1'b1, pc, model_stable(pc), $sformatf("rand%0d", i));
      end

      render(13'h0000, 1'b1, 1'b1);
      l = 11'd200; t = 10'd100;
      pc = model_code();
      latch_check(1'b1, pc, model_stable(pc), "rand_last");
      render12(100, 200);
      rst = 1'b1;
      pix_valid = 1'b0;
      step();
      check("midrst_code", 32'(seg_code), 32'd0);
      check("midrst_valid", 32'(code_valid), 32'd0);
      check("midrst_stable", 32'(code_stable), 32'd0);
      rst = 1'b0;
      m_active = 1'b0;
      hist.delete();
      model_clear();
      render12(300, 300);
      latch_check(1'b0, 13'h0000, 1'b0, "post_rst_latch1");
      render(13'h0C18, 1'b0, 1'b1);
      latch_check(1'b1, 13'h0C18, 1'b0, "post_rst_latch2");

      check("spurious_code_valid", 32'(n_spur), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/numread.md
NUMREAD -- requirements
Module: numread

Interface
REQ-001 Parameter width, 11'd70: digit cell width in pixels (x2 - x1).
REQ-002 Parameter high, 10'd140: digit cell height in pixels (y3 - y1).
REQ-003 Parameter m_t, 10'd66: middle-bar row offset (y2 - y1).
REQ-004 Parameter d, 4'd8: segment stroke thickness.
REQ-005 Parameter L1, 11'd150 / L2, 10'd150: bounding-box width / height.
REQ-006 Parameter DARK_TH, 8'd64: per-channel darkness threshold.
REQ-007 Parameter STABLE_N, 3'd3: consecutive identical frames required for code_stable.
REQ-008 clk  input  1  sole clock; all logic on posedge clk.
REQ-009 rst  input  1  reset, synchronous, active-high.
REQ-010 l  input  11  bounding-box left x.
REQ-011 t  input  10  bounding-box top y.
REQ-012 RGB_x_Src  input  11  current pixel x.
REQ-013 RGB_y_Src  input  10  current pixel y.
REQ-014 RGB_Data_In  input  24  current pixel colour, {R,G,B}.
REQ-015 pix_valid  input  1  pixel beat qualifier; pixels with pix_valid=0 are ignored.
REQ-016 seg_code  output  13  recovered segment code, same bit map as the digit renderer.
REQ-017 code_valid  output  1  one-cycle pulse when seg_code updates.
REQ-018 code_stable  output  1  high while the last STABLE_N codes were identical.

Function
REQ-019 Geometry shall be latched on the cycle (RGB_x_Src,RGB_y_Src)==(100,1): x1=l+40, x2=l+width+40, y1=t+5, y2=t+m_t+5, y3=t+high+5, r=l+L1, b=t+L2.
REQ-020 A pixel shall be dark when R<DARK_TH, G<DARK_TH and B<DARK_TH.
REQ-021 Only pixels with pix_valid=1 inside l<=x<=r, t<=y<=b shall be classified; first-match priority: bits 12,11,10,9,8,7,6,5,4,3,2,1,0.
REQ-022 Bar regions (inclusive): 12 x∈[x1+d,x2-d], y∈[y1,y1+d]; 11 x∈[x2-d,x2], y∈[y1+d,y2]; 10 x∈[x2-d,x2], y∈[y2+d,y3-d]; 9 x∈[x1+d,x2-d], y∈[y3-d,y3]; 8 x∈[x1,x1+d], y∈[y2+d,y3-d]; 7 x∈[x1,x1+d], y∈[y1+d,y2]; 6 x∈[x1+d,x2-d], y∈[y2,y2+d].
REQ-023 Corner regions (strict): 5 x∈(x1,x1+d), y∈(y1,y1+d); 4 x∈(x2-d,x2), y∈(y1,y1+d); 3 x∈(x2-d,x2), y∈(y2,y2+d); 2 x∈(x2-d,x2), y∈(y3-d,y3); 1 x∈(x1,x1+d), y∈(y3-d,y3); 0 x∈(x1,x1+d), y∈(y2,y2+d).
REQ-024 Per region, 10-bit total and dark counters shall increment on each classified pixel, saturating at 1023.
REQ-025 FSM states: WAIT (after reset, until first latch point), ACC (accumulating), EVAL (one cycle).
REQ-026 WAIT -> ACC at first latch point: counters cleared, geometry latched, no code_valid.
REQ-027 ACC -> EVAL at each latch point; the pixel on the latch cycle shall not be counted.
REQ-028 EVAL: bit n of seg_code = (2*dark_n > total_n), 11-bit compare; total_n=0 gives 0; counters cleared; code_valid=1 this cycle; EVAL -> ACC next cycle.
REQ-029 code_valid therefore rises one cycle after the latch-point cycle and lasts exactly one cycle.
REQ-030 seg_code shall hold between updates.
REQ-031 A run counter shall increment (saturating at STABLE_N) when the new code equals the previous one, else reset to 1; code_stable = (run == STABLE_N), updated with code_valid.
REQ-032 Changes of l/t mid-frame shall take effect only at the next latch point.
REQ-033 A latch point during EVAL cannot occur (one-cycle EVAL, latch point once per frame); rst has priority over all events.

Reset
REQ-034 rst=1 shall set state=WAIT, seg_code=0, code_valid=0, code_stable=0, run=0, all counters=0, geometry registers=0.
REQ-035 rst asserted mid-frame shall discard partial counts; the first code_valid after release follows the second subsequent latch point.

Verification
REQ-036 l=200,t=100, frame rendering code 13'h1FFF (all segments black {1,1,1}) -> after second latch point, code_valid 1-cycle pulse, seg_code=13'h1FFF.
REQ-037 Same box, all-white frame -> seg_code=13'h0000, code_valid pulses.
REQ-038 Digit "1" code 13'h0C18 (bits 11,10,4,3) for 3 frames -> code_stable=1 after third code_valid; fourth frame 13'h1FFF -> code_stable=0.
REQ-039 Region 12 with exactly half its 495 pixels dark (247) -> bit 12=0; with 248 dark -> bit 12=1.
REQ-040 pix_valid=0 over whole frame -> seg_code=0; rst pulse mid-frame -> all outputs 0, no code_valid until second latch point.
